cpu_sequencer: RTL and testbench

//  Control FSM for the accumulator CPU datapath.
//  - Fetches 6-bit instructions from program memory over a req/ack handshake.
//  - Holds the fetched word in an instruction register that drives the instruction decoder.
//  - Emits a one-cycle execute strobe that gates the decoder's ALU/RF/A enables.
//  - Keeps the program counter and supports run, single-step, stop, halt and fetch-timeout fault.

---
 rtl/cpu_sequencer_if.sv | 13 +
 rtl/cpu_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and program memory.
// The sequencer holds req for the whole fetch; the memory returns data with a one-cycle ack.
interface cpu_sequencer_if #(
    parameter int unsigned PC_W = 4
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [5:0]      imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the accumulator CPU.
// Owns the PC and the instruction register; all outputs come from registers or the state.
module cpu_sequencer #(
    parameter int unsigned PC_W        = 4,
    parameter logic [3:0]  HALT_OPCODE = 4'b1111,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   step_mode,
    cpu_sequencer_if.master        imem,
    output logic [5:0]             instr,
    output logic                   exec_stb,
    output logic [PC_W-1:0]        pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   fault
);
    localparam int unsigned     WC_W      = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] LAST_WAIT = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, HALTED, FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [5:0]      instr_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            stop_pend, stop_pend_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr     <= '0;
            wait_cnt  <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr     <= instr_nxt;
            wait_cnt  <= wait_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instr;
        wait_nxt      = wait_cnt;
        stop_pend_nxt = stop_pend;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    wait_nxt  = '0;
                end
            end
            FETCH: begin
                if (stop) stop_pend_nxt = 1'b1;
                // An ack on the final allowed cycle still beats the timeout.
                if (imem.imem_ack) begin
                    instr_nxt = imem.imem_data;
                    state_nxt = DECODE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = FAULT;
                end else begin
                    wait_nxt = wait_cnt + WC_W'(1);
                end
            end
            DECODE: begin
                if (stop) stop_pend_nxt = 1'b1;
                state_nxt = EXECUTE;
            end
            EXECUTE: begin
                if (instr[5:2] == HALT_OPCODE) begin
                    state_nxt = HALTED;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                    if (stop_pend || stop) begin
                        state_nxt     = IDLE;
                        stop_pend_nxt = 1'b0;
                    end else if (step_mode) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FETCH;
                        wait_nxt  = '0;
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    pc_nxt    = '0;
                    wait_nxt  = '0;
                    state_nxt = FETCH;
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign exec_stb       = (state == EXECUTE);
    assign busy           = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
    assign halted         = (state == HALTED);
    assign fault          = (state == FAULT);
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised bench for cpu_sequencer: a memory responder with random wait states feeds the DUT,
// an architectural model predicts the executed (pc, instr) stream and a monitor scores each exec_stb.
module tb_cpu_sequencer;
    localparam int unsigned PC_W = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0, stop = 1'b0, step_mode = 1'b0;
    logic [5:0]      instr;
    logic            exec_stb, busy, halted, fault;
    logic [PC_W-1:0] pc;

    cpu_sequencer_if #(.PC_W(PC_W)) bus ();

    cpu_sequencer #(.PC_W(PC_W), .HALT_OPCODE(4'b1111), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
        .imem(bus), .instr(instr), .exec_stb(exec_stb), .pc(pc),
        .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [5:0] mem [16];
    logic [PC_W+5:0] exp_q [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder: random wait states per fetch, garbage data and stray acks outside fetches.
    int dly_min = 0, dly_max = 0, wctr = 0, cur_dly = 0;
    bit no_ack = 0, spur = 1, in_fetch = 0;
    always @(negedge clk) begin
        bus.imem_data = 6'($urandom);
        if (bus.imem_req === 1'b1) begin
            if (!in_fetch) begin
                in_fetch = 1;
                wctr = 0;
                cur_dly = $urandom_range(dly_max, dly_min);
            end
            if (!no_ack && wctr == cur_dly) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = mem[bus.imem_addr];
                in_fetch = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wctr++;
            end
        end else begin
            in_fetch = 0;
            bus.imem_ack = spur ? 1'($urandom) : 1'b0;
        end
    end

    // Monitor: every exec_stb cycle must match the next predicted instruction.
    int cyc = 0, last_exec = -1;
    bit chk_tput = 0;
    always @(negedge clk) begin
        cyc++;
        if (exec_stb !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("exec_unexpected", {22'b0, pc, instr}, 32'h3ff);
            end else begin
                logic [PC_W+5:0] e;
                e = exp_q.pop_front();
                chk("exec_pc_instr", {22'b0, pc, instr}, {22'b0, e});
            end
            if (chk_tput && last_exec >= 0) chk("throughput", 32'(cyc - last_exec), 3);
            last_exec = cyc;
        end
    end

    // Architectural model: execute from pc until n instructions or a halt word.
    logic [PC_W-1:0] m_pc = '0;
    bit m_halted = 0;
    task automatic predict(int n);
        if (m_halted) begin m_pc = '0; m_halted = 0; end
        for (int i = 0; i < n; i++) begin
            logic [5:0] w;
            w = mem[m_pc];
            exp_q.push_back({m_pc, w});
            if (w[5:2] == 4'b1111) begin m_halted = 1; break; end
            m_pc = m_pc + 1'b1;
        end
    endtask

    task automatic pulse_start(bit with_stop);
        start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int i = 0;
        while (busy && i < 400) begin @(negedge clk); i++; end
        chk(nm, {31'b0, busy}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pc = '0; m_halted = 0;
        @(negedge clk);
    endtask

    function automatic logic [5:0] rand_word();
        return 6'($urandom_range(0, 59));
    endfunction

    initial begin
        int nreq;
        bit found;
        for (int i = 0; i < 16; i++) mem[i] = rand_word();

        // Reset state
        @(negedge clk);
        chk("rst_outs", {15'b0, pc, instr, exec_stb, busy, halted, fault, bus.imem_req},
            0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {15'b0, pc, instr, exec_stb, busy, halted, fault, bus.imem_req},
            0);

        // 1: single instruction, zero-wait, cycle-accurate strobe
        step_mode = 1'b1;
        mem[0] = 6'b000101;
        predict(1);
        pulse_start(0);
        chk("t1_fetch", {29'b0, bus.imem_req, busy, exec_stb}, 3'b110);
        chk("t1_addr", 32'(bus.imem_addr), 0);
        @(negedge clk);
        chk("t1_decode_stb", {31'b0, exec_stb}, 0);
        @(negedge clk);
        chk("t1_exec_stb", {31'b0, exec_stb}, 1);
        @(negedge clk);
        chk("t1_after", {21'b0, exec_stb, busy, pc, instr}, {21'b0, 2'b00, 4'd1, 6'b000101});

        // 2: 16-word program, wrap 15->0, then stop
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = rand_word();
        step_mode = 1'b0;
        predict(17);
        chk_tput = 1; last_exec = -1;
        pulse_start(0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (exec_stb && pc == 4'd15) found = 1;
        end
        chk("t2_reach_15", {31'b0, found}, 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t2_idle");
        chk_tput = 0;
        chk("t2_pc", 32'(pc), 1);

        // 3: halt word at address 3, random wait states
        dly_min = 0; dly_max = 3;
        mem[3] = 6'b111100;
        predict(100);
        pulse_start(0);
        wait_idle("t3_stop");
        chk("t3_halt", {28'b0, halted, busy, fault, exec_stb}, 4'b1000);
        chk("t3_pc", 32'(pc), 3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        nreq = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); nreq += int'(bus.imem_req); end
        chk("t3_no_req", 32'(nreq), 0);
        chk("t3_still_halted", {31'b0, halted}, 1);
        predict(100);
        pulse_start(0);
        chk("t3_restart_addr", {27'b0, bus.imem_req, bus.imem_addr}, {27'b0, 1'b1, 4'd0});
        wait_idle("t3_rehalt");
        chk("t3_rehalt_pc", {27'b0, halted, pc}, {27'b0, 1'b1, 4'd3});

        // 4: single-step, stop during a delayed fetch, start+stop together
        mem[3] = rand_word();
        step_mode = 1'b1;
        predict(1);
        pulse_start(0);
        wait_idle("t4_step");
        chk("t4_step_state", {27'b0, halted, pc}, {27'b0, 1'b0, 4'd1});
        step_mode = 1'b0;
        dly_min = 2; dly_max = 2;
        predict(1);
        pulse_start(0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t4_stop");
        chk("t4_stop_pc", 32'(pc), 2);
        dly_min = 0; dly_max = 0;
        predict(2);
        pulse_start(1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (exec_stb) found = 1;
            else @(negedge clk);
        end
        chk("t4_start_wins", {31'b0, found}, 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("t4_start_stop");
        chk("t4_start_stop_pc", 32'(pc), 4);

        // 5: ack on the last allowed cycle, then fetch timeout
        step_mode = 1'b1;
        dly_min = 7; dly_max = 7;
        predict(1);
        pulse_start(0);
        wait_idle("t5_late_ack");
        chk("t5_late_ack", {27'b0, fault, pc}, {27'b0, 1'b0, 4'd5});
        no_ack = 1;
        pulse_start(0);
        nreq = 0;
        for (int i = 0; i < 20 && !fault; i++) begin
            nreq += int'(bus.imem_req);
            @(negedge clk);
        end
        chk("t5_fetch_cycles", 32'(nreq), 8);
        chk("t5_fault", {28'b0, fault, bus.imem_req, busy, exec_stb}, 4'b1000);
        pulse_start(0);
        repeat (3) @(negedge clk);
        chk("t5_sticky", {30'b0, fault, bus.imem_req}, 2'b10);
        no_ack = 0;
        rst = 1'b1;
        #1;
        chk("t5_rst_clears", {31'b0, fault}, 0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = '0; m_halted = 0;
        @(negedge clk);

        // 6: reset during DECODE abandons the instruction
        step_mode = 1'b0;
        dly_min = 0; dly_max = 0;
        pulse_start(0);
        @(negedge clk);
        chk("t6_in_decode", {30'b0, busy, exec_stb}, 2'b10);
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", {15'b0, pc, instr, exec_stb, busy, halted, fault, bus.imem_req},
            0);
        @(negedge clk);
        chk("t6_no_stb_in_rst", {31'b0, exec_stb}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_stb_after", {30'b0, exec_stb, busy}, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
